mxv_row_mac: RTL and testbench

MXV_ROW_MAC -- requirements
Module: mxv_row_mac

---
 rtl/mxv_pkg.sv | 24 ++
 rtl/mxv_mac_unit.sv | 29 ++
 rtl/mxv_row_mac.sv | 83 ++++++++
 tb/tb_mxv_row_mac.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxv_pkg.sv
// Shared types and defaults for the matrix-vector row MAC.
package mxv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_VECTOR_LENGTH = 8;
    localparam int DEF_ACC_WIDTH     = 16;

    // Never returns less than 1 so a length-1 vector still gets a real index port.
    function automatic int CeilLog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mxv_mac_unit.sv
// Combinational acc + a*b. Macro MXV_SATURATE_EN clamps the sum at the accumulator maximum,
// otherwise it wraps modulo 2^ACC_WIDTH.
module mxv_mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  sum
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0] product;
    assign product = a * b;

`ifdef MXV_SATURATE_EN
    // One guard bit above the wider operand catches every carry out of the accumulator.
    localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
    localparam logic [SW-1:0] ACC_MAX = SW'({ACC_WIDTH{1'b1}});

    logic [SW-1:0] wide;
    assign wide = SW'(acc) + SW'(product);
    assign sum  = (wide > ACC_MAX) ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
`else
    assign sum = acc + ACC_WIDTH'(product);
`endif

endmodule

// File: rtl/mxv_row_mac.sv
// Row dot-product engine: pops one FIFO word per element, multiplies by the addressed
// vector element and publishes the row sum. Overflow mode set by macro MXV_SATURATE_EN.
module mxv_row_mac
    import mxv_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int VECTOR_LENGTH   = DEF_VECTOR_LENGTH,
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int NBITS_FOR_INDEX = CeilLog2(VECTOR_LENGTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       flag_empty,
    output logic                       pop,
    input  logic [DATA_WIDTH-1:0]      fifo_data,
    input  logic [DATA_WIDTH-1:0]      vector_element,
    output logic [NBITS_FOR_INDEX-1:0] vector_index,
    output logic [ACC_WIDTH-1:0]       row_result,
    output logic                       result_valid,
    output logic                       busy
);
    localparam logic [NBITS_FOR_INDEX-1:0] LAST_IDX = NBITS_FOR_INDEX'(VECTOR_LENGTH - 1);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] mac_sum;

    mxv_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .acc (acc),
        .a   (fifo_data),
        .b   (vector_element),
        .sum (mac_sum)
    );

    // Pop is decided on the flag as seen this cycle; READ always follows, so pops are spaced.
    assign pop  = (state == WAIT) && !flag_empty;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            vector_index <= '0;
            row_result   <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc          <= '0;
                        vector_index <= '0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (pop) state <= READ;
                end
                READ: begin
                    acc <= mac_sum;
                    if (vector_index == LAST_IDX) begin
                        row_result   <= mac_sum;
                        vector_index <= '0;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        vector_index <= vector_index + 1'b1;
                        state        <= WAIT;
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mxv_row_mac.sv
// Scoreboard bench for mxv_row_mac (VECTOR_LENGTH=4, DATA_WIDTH=8, ACC_WIDTH=16).
module tb_mxv_row_mac;
    localparam int DW = 8;
    localparam int VL = 4;
    localparam int AW = 16;
    localparam int IW = 2;
    localparam longint ACC_MAX = (longint'(1) << AW) - 1;

    typedef int row_t [VL];
    typedef struct {
        longint sum;
        longint t0;
        int     lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          flag_empty;
    logic          pop;
    logic [DW-1:0] fifo_data;
    logic [DW-1:0] vector_element;
    logic [IW-1:0] vector_index;
    logic [AW-1:0] row_result;
    logic          result_valid;
    logic          busy;

    logic [DW-1:0] vec_arr [VL];
    logic [DW-1:0] fifo_q [$];
    exp_t          sb_q [$];

    int     errors = 0;
    int     checks = 0;
    int     n_results = 0;
    int     pops_total = 0;
    longint cyc = 0;
    longint prev_expected = 0;

    always #5 clk = ~clk;

    assign vector_element = vec_arr[vector_index];

    mxv_row_mac #(
        .DATA_WIDTH    (DW),
        .VECTOR_LENGTH (VL),
        .ACC_WIDTH     (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .flag_empty     (flag_empty),
        .pop            (pop),
        .fifo_data      (fifo_data),
        .vector_element (vector_element),
        .vector_index   (vector_index),
        .row_result     (row_result),
        .result_valid   (result_valid),
        .busy           (busy)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain dot product, then the accumulator's overflow rule on the total.
    function automatic longint model(input row_t d, input row_t v);
        longint s = 0;
        for (int i = 0; i < VL; i++) s += longint'(d[i]) * longint'(v[i]);
`ifdef MXV_SATURATE_EN
        if (s > ACC_MAX) s = ACC_MAX;
`else
        s = s % (ACC_MAX + 1);
`endif
        return s;
    endfunction

    task automatic cycle_counter();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // Upstream FIFO: data for a pop is presented before the following READ cycle.
    task automatic fifo_model();
        forever begin
            @(negedge clk);
            if (pop) begin
                if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
                pops_total++;
            end
        end
    endtask

    task automatic monitor();
        logic pp = 1'b0;
        logic prv = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (pop) chk("pop_legal", {!flag_empty, !pp, busy}, 3'b111);
            if (result_valid) begin
                chk("rv_pulse", prv, 0);
                if (sb_q.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("row_result", row_result, e.sum);
                    if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
                end
                n_results++;
            end
            pp  = pop;
            prv = result_valid;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue_start(input row_t d, input row_t v, output int base_p, output int base_r);
        wait_idle();
        for (int i = 0; i < VL; i++) begin
            vec_arr[i] = DW'(v[i]);
            fifo_q.push_back(DW'(d[i]));
        end
        @(posedge clk); #1;
        start = 1'b1;
        flag_empty = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        base_p = pops_total;
        base_r = n_results;
    endtask

    task automatic run_row(input row_t d, input row_t v, input int stall_len,
                           input bit rnd, input bit ghost, input int lat);
        exp_t e;
        int base_p, base_r;
        int seen = 0, scnt = 0, guard = 0;
        bit stalled;
        issue_start(d, v, base_p, base_r);
        e.sum = model(d, v);
        e.t0  = cyc;
        e.lat = lat;
        sb_q.push_back(e);
        while (n_results == base_r && guard < 400) begin
            guard++;
            stalled = 1'b0;
            if (ghost) start = (guard == 3);
            if (stall_len > 0 && pops_total - base_p == 2) seen++;
            if (stall_len > 0 && seen >= 2 && scnt < stall_len) begin
                flag_empty = 1'b1;
                scnt++;
                stalled = 1'b1;
            end else begin
                flag_empty = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            @(negedge clk);
            if (stalled) begin
                chk("stall_pop", pop, 0);
                chk("stall_hold", row_result, prev_expected);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        flag_empty = 1'b0;
        if (n_results == base_r) chk("row_timeout", 0, 1);
        prev_expected = e.sum;
        if (ghost) begin
            repeat (3 * VL) @(posedge clk);
            #1;
            chk("ghost_extra", n_results, base_r + 1);
            chk("idle_after", busy, 0);
        end
    endtask

    initial begin
        row_t d, v;
        int base_p, base_r, g;

        reset = 1'b1;
        start = 1'b0;
        flag_empty = 1'b1;
        fifo_data = '0;
        for (int i = 0; i < VL; i++) vec_arr[i] = '0;
        fork
            cycle_counter();
            fifo_model();
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_result", row_result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_pop", pop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vector_index", vector_index, 0);
        reset = 1'b0;

        d = '{1, 2, 3, 4};
        v = '{1, 1, 1, 1};
        run_row(d, v, 0, 1'b0, 1'b0, 2 * VL);
        run_row(d, v, 5, 1'b0, 1'b0, 2 * VL + 5);

        d = '{255, 255, 255, 255};
        v = '{255, 255, 255, 255};
        run_row(d, v, 0, 1'b0, 1'b0, 2 * VL);

        d = '{9, 8, 7, 6};
        v = '{2, 3, 4, 5};
        run_row(d, v, 0, 1'b0, 1'b1, 2 * VL);

        // Abort a row after two elements with an asynchronous reset.
        d = '{5, 6, 7, 8};
        v = '{1, 1, 1, 1};
        issue_start(d, v, base_p, base_r);
        g = 0;
        while (pops_total - base_p < 2 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (pops_total - base_p < 2) chk("abort_wait", 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_row_result", row_result, 0);
        chk("abort_pop", pop, 0);
        chk("abort_vector_index", vector_index, 0);
        chk("abort_result_valid", result_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        fifo_q.delete();
        prev_expected = 0;

        d = '{2, 2, 2, 2};
        v = '{3, 3, 3, 3};
        run_row(d, v, 0, 1'b0, 1'b0, 2 * VL);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < VL; i++) begin
                d[i] = int'($urandom_range(0, 255));
                v[i] = int'($urandom_range(0, 255));
            end
            run_row(d, v, 0, 1'b1, 1'b0, -1);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
